// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence detector.
// Shifts WIDTH-bit words out one bit per clock, with optional idle gap.
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter int   GAP       = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);
  localparam logic [3:0] GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             ser_q, ser_d;
  logic             sv_q, sv_d;
  logic             done_q, done_d;

  logic last_bit;
  logic last_gap;
  logic accept;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign last_bit = (state_q == S_SHIFT) && (bit_cnt_q == LAST);
  assign last_gap = (state_q == S_GAP) && (gap_cnt_q == GAP_LAST);

  assign ready_out = (state_q == S_IDLE)
                   | (last_bit & (GAP == 0))
                   | last_gap;
  assign accept = valid_in & ready_out;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ser_d     = ser_q;
    sv_d      = sv_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ser_d = IDLE_BIT;
        sv_d  = 1'b0;
      end
      S_SHIFT: begin
        if (bit_cnt_q == LAST) begin
          ser_d = IDLE_BIT;
          sv_d  = 1'b0;
          if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          ser_d     = head(shreg_q);
          shreg_d   = adv(shreg_q);
          sv_d      = 1'b1;
          done_d    = (bit_cnt_q == PRE_LAST);
        end
      end
      S_GAP: begin
        ser_d = IDLE_BIT;
        sv_d  = 1'b0;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ser_d   = IDLE_BIT;
        sv_d    = 1'b0;
      end
    endcase

    // A load overrides whatever the current state chose for next cycle.
    if (accept) begin
      state_d   = S_SHIFT;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
      ser_d     = head(data_in);
      shreg_d   = adv(data_in);
      sv_d      = 1'b1;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ser_q     <= IDLE_BIT;
      sv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ser_q     <= ser_d;
      sv_q      <= sv_d;
      done_q    <= done_d;
    end
  end

  assign ser_out   = ser_q;
  assign ser_valid = sv_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three configurations against a
// cycle-occupancy reference model plus directed corner sequences.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid [3];
  logic       rdy [3];
  logic       ser [3];
  logic       sv [3];
  logic       dn [3];
  logic       bsy [3];

  int checks = 0;
  int failures = 0;

  int pw [3] = '{8, 8, 4};
  int pm [3] = '{1, 0, 1};
  int pg [3] = '{1, 0, 1};

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(1), .IDLE_BIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .data_in(data), .valid_in(valid[0]),
    .ready_out(rdy[0]), .ser_out(ser[0]), .ser_valid(sv[0]),
    .done(dn[0]), .busy(bsy[0])
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(0), .IDLE_BIT(1'b0)) u1 (
    .clk(clk), .rst(rst), .data_in(data), .valid_in(valid[1]),
    .ready_out(rdy[1]), .ser_out(ser[1]), .ser_valid(sv[1]),
    .done(dn[1]), .busy(bsy[1])
  );

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP(1), .IDLE_BIT(1'b0)) u2 (
    .clk(clk), .rst(rst), .data_in(data[3:0]), .valid_in(valid[2]),
    .ready_out(rdy[2]), .ser_out(ser[2]), .ser_valid(sv[2]),
    .done(dn[2]), .busy(bsy[2])
  );

  task automatic chk(input string nm, input int k,
                     input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%b want=%b", nm, k, $time, act, exp);
    end
  endtask

  // Model: each accepted word occupies W+GAP cycles; free when <=1 left.
  int         rem [3];
  logic [7:0] mword [3];
  logic       macc [3];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        rem[k] = 0;
        mword[k] = 8'h00;
        macc[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        macc[k] = valid[k] && (rem[k] <= 1);
        if (macc[k]) begin
          rem[k] = pw[k] + pg[k];
          mword[k] = data;
        end else if (rem[k] > 0) begin
          rem[k] = rem[k] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin : checker_b
    int   pos;
    logic ev;
    logic eb;
    if (rst === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        pos = pw[k] + pg[k] - rem[k];
        ev = (rem[k] > 0) && (pos < pw[k]);
        eb = 1'b0;
        if (ev) eb = (pm[k] != 0) ? mword[k][pw[k]-1-pos] : mword[k][pos];
        chk("m_ser", k, ser[k], eb);
        chk("m_valid", k, sv[k], ev);
        chk("m_done", k, dn[k], ev && (pos == pw[k] - 1));
        chk("m_busy", k, bsy[k], rem[k] > 0);
        chk("m_ready", k, rdy[k], rem[k] <= 1);
      end
    end
  end

  logic cb [32];
  logic cv [32];
  logic cd [32];
  logic cr [32];
  logic cy [32];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] w, input bit hold);
    bit ok;
    data = w;
    valid[k] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = macc[k];
    end
    if (!hold) valid[k] = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout dut%0d got=no_accept want=accept", k);
    end
  endtask

  task automatic collect(input int k, input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cb[i] = ser[k];
      cv[i] = sv[k];
      cd[i] = dn[k];
      cr[i] = rdy[k];
      cy[i] = bsy[k];
      if (i == drop_at) begin
        @(posedge clk);
        #1 valid[k] = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] s_msb;
    logic [7:0] s_lsb;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [7:0]  s;
    logic [15:0] s16;
    logic [3:0]  hist;
    logic [4:0]  golden;

    rst = 1'b0;
    data = 8'h00;
    for (int k = 0; k < 3; k++) valid[k] = 1'b0;

    // Stream literals list bits in send order, first bit leftmost.
    tbl[0] = '{8'hB4, 8'b10110100, 8'b00101101};
    tbl[1] = '{8'h0F, 8'b00001111, 8'b11110000};
    tbl[2] = '{8'h55, 8'b01010101, 8'b10101010};
    tbl[3] = '{8'h01, 8'b00000001, 8'b10000000};
    tbl[4] = '{8'h80, 8'b10000000, 8'b00000001};
    tbl[5] = '{8'hFF, 8'b11111111, 8'b11111111};

    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ser", k, ser[k], 1'b0);
      chk("rst_valid", k, sv[k], 1'b0);
      chk("rst_done", k, dn[k], 1'b0);
      chk("rst_busy", k, bsy[k], 1'b0);
    end
    rst = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) chk("rst_ready", k, rdy[k], 1'b1);

    // Single word, MSB first, one gap bit.
    send(0, 8'hB4, 1'b0);
    collect(0, 9, -1);
    s = 8'b10110100;
    for (int i = 0; i < 8; i++) begin
      chk("t1_bit", 0, cb[i], s[7-i]);
      chk("t1_valid", 0, cv[i], 1'b1);
      chk("t1_done", 0, cd[i], i == 7);
    end
    chk("t1_c9_ser", 0, cb[8], 1'b0);
    chk("t1_c9_valid", 0, cv[8], 1'b0);
    chk("t1_c9_ready", 0, cr[8], 1'b1);
    tick();

    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 2; k++) begin
        send(k, tbl[e].word, 1'b0);
        collect(k, 8, -1);
        s = (k == 0) ? tbl[e].s_msb : tbl[e].s_lsb;
        for (int i = 0; i < 8; i++) begin
          chk("tbl_bit", k, cb[i], s[7-i]);
          chk("tbl_done", k, cd[i], i == 7);
        end
        repeat (2) tick();
      end
    end

    // Two queued words with one idle bit between them.
    send(0, 8'hB4, 1'b1);
    data = 8'h0F;
    collect(0, 17, 8);
    s16 = {8'b10110100, 8'b00001111};
    for (int i = 0; i < 8; i++) chk("t2_w0", 0, cb[i], s16[15-i]);
    chk("t2_gap_ser", 0, cb[8], 1'b0);
    chk("t2_gap_valid", 0, cv[8], 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("t2_w1", 0, cb[9+i], s16[7-i]);
      chk("t2_w1_valid", 0, cv[9+i], 1'b1);
    end
    for (int i = 0; i < 17; i++) chk("t2_done", 0, cd[i], i == 7 || i == 16);
    repeat (3) tick();

    // Back-to-back, LSB first, no gap.
    send(1, 8'h01, 1'b1);
    data = 8'h80;
    collect(1, 16, 7);
    s16 = 16'b1000000000000001;
    for (int i = 0; i < 16; i++) begin
      chk("t3_bit", 1, cb[i], s16[15-i]);
      chk("t3_valid", 1, cv[i], 1'b1);
      chk("t3_ready", 1, cr[i], i == 7 || i == 15);
    end
    repeat (3) tick();

    // Four-bit word into a "1001" overlapping detector.
    send(2, 8'h09, 1'b0);
    collect(2, 5, -1);
    s = 8'b10010000;
    golden = 5'b00010;
    hist = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk("t4_in", 2, cb[i], s[7-i]);
      hist = {hist[2:0], cb[i]};
      chk("t4_fsm", 2, hist == 4'b1001, golden[4-i]);
    end
    repeat (3) tick();

    // Valid pulsed while busy must be ignored.
    send(0, 8'hB4, 1'b0);
    collect(0, 2, -1);
    data = 8'hFF;
    valid[0] = 1'b1;
    tick();
    tick();
    valid[0] = 1'b0;
    collect(0, 7, -1);
    s = 8'b10110100;
    for (int i = 0; i < 5; i++) chk("t5_bit", 0, cb[i], s[4-i]);
    chk("t5_gap_valid", 0, cv[5], 1'b0);
    chk("t5_idle_busy", 0, cy[6], 1'b0);
    chk("t5_idle_valid", 0, cv[6], 1'b0);
    send(0, 8'hFF, 1'b0);
    collect(0, 8, -1);
    for (int i = 0; i < 8; i++) chk("t5_ff", 0, cb[i], 1'b1);
    repeat (3) tick();

    // Asynchronous reset during the fourth bit.
    send(0, 8'hB4, 1'b0);
    collect(0, 3, -1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_ser", 0, ser[0], 1'b0);
    chk("t6_valid", 0, sv[0], 1'b0);
    chk("t6_busy", 0, bsy[0], 1'b0);
    chk("t6_done", 0, dn[0], 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("t6_rst_done", 0, dn[0], 1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    collect(0, 6, -1);
    for (int i = 0; i < 6; i++) begin
      chk("t6_post_done", 0, cd[i], 1'b0);
      chk("t6_post_valid", 0, cv[i], 1'b0);
    end
    send(0, 8'h55, 1'b0);
    collect(0, 8, -1);
    s = 8'b01010101;
    for (int i = 0; i < 8; i++) begin
      chk("t6_55", 0, cb[i], s[7-i]);
      chk("t6_55_done", 0, cd[i], i == 7);
    end
    tick();

    // Random traffic, checked every cycle against the model.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (!valid[k]) valid[k] = ($urandom_range(0, 2) == 0);
        else if (macc[k]) valid[k] = ($urandom_range(0, 2) != 0);
      end
      data = 8'($urandom);
      tick();
    end
    for (int k = 0; k < 3; k++) valid[k] = 1'b0;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end for the sequence-detector FSM. Accepts WIDTH-bit words over a valid/ready handshake. Shifts each word out one bit per clock on ser_out, which drives the FSM's single-bit `in`. An optional inter-word gap of fixed idle bits is inserted between words.

Parameters:
WIDTH, 8, bits per word (2..32)
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
GAP, 1, idle-bit cycles inserted after each word (0..15); 0 = back-to-back
IDLE_BIT, 0, level driven on ser_out when no word bit is being sent

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
data_in  input  WIDTH  word to serialize
valid_in  input  1  data_in valid; held by upstream until accepted
ready_out  output  1  block can accept a word this cycle
ser_out  output  1  serial bit, registered; connects to FSM `in`
ser_valid  output  1  high while ser_out carries a word bit (not idle/gap)
done  output  1  one-cycle pulse coincident with last bit of a word on ser_out
busy  output  1  high in SHIFT or GAP

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ser_out=IDLE_BIT, ser_valid=0, done=0, busy=0, shift reg=0, bit counter=0, gap counter=0. ready_out=1 once reset deasserts.
- Accept = valid_in & ready_out sampled at a rising edge. data_in is latched into the shift register at that edge.
- States:
  - IDLE:
    - ready_out=1, ser_out=IDLE_BIT, ser_valid=0.
    - On accept -> SHIFT.
  - SHIFT:
    - ser_out presents one word bit per cycle. MSB_FIRST selects order.
    - Bit counter runs 0..WIDTH-1. ser_valid=1.
    - On the last bit cycle: done=1.
    - From the last bit cycle: if GAP>0 -> GAP. If GAP=0 and accept -> reload and stay SHIFT. Otherwise -> IDLE.
  - GAP:
    - ser_out=IDLE_BIT, ser_valid=0, for exactly GAP cycles.
    - From the final GAP cycle: on accept -> SHIFT, otherwise -> IDLE.
- Latency: the first bit of an accepted word appears on ser_out in the cycle immediately after the accepting edge.
- ready_out (combinational from state/counters):
  - 1 in IDLE.
  - 1 in the last SHIFT cycle only when GAP=0.
  - 1 in the final GAP cycle.
  - 0 otherwise.
- Back-to-back words:
  - GAP=0: words are contiguous, with no idle bit between them.
  - GAP>0: exactly GAP idle bits separate words.
- valid_in while ready_out=0: ignored, no latch. data_in may change freely while not accepted.
- Reset mid-word: current word is discarded immediately, outputs return to reset values. No partial done pulse.
- Counters are sized to clog2(WIDTH) and 4 bits respectively. No wrap beyond WIDTH-1 or GAP-1.

Test Plan:
1. Reset, then WIDTH=8, MSB_FIRST=1, GAP=1, send 0xB4:
   - ser_out over the 8 cycles after the accepting edge = 1,0,1,1,0,1,0,0.
   - ser_valid=1 throughout; done=1 on the 8th cycle only.
   - Cycle 9: ser_out=0, ser_valid=0, ready_out=1.
2. Same config, valid_in held high with 0xB4 then 0x0F queued:
   - Exactly one idle bit between words.
   - Second word bits = 0,0,0,0,1,1,1,1.
   - done pulses twice, 9 cycles apart.
3. GAP=0, MSB_FIRST=0, words 0x01 then 0x80 back-to-back:
   - 16 contiguous bits = 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1.
   - ready_out high only on the 8th and 16th bit cycles.
4. WIDTH=4, word 0b1001 with GAP=1, feeding an FSM instance:
   - FSM `in` sequence = 1,0,0,1,0.
   - FSM output matches its golden trace for that sequence.
5. valid_in pulsed with 0xFF while busy (ready_out=0):
   - Word not accepted, ser_out unaffected.
   - Word is accepted only after valid_in is re-asserted in a ready cycle.
6. Assert rst low at the 4th bit of 0xB4:
   - ser_out=0, ser_valid=0, busy=0 immediately, asynchronously before the next edge.
   - No done pulse.
   - After release, 0x55 serializes as 0,1,0,1,0,1,0,1.
